fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream_pkg.sv | 26 ++
 rtl/fifo_rd_stream_if.sv | 16 +
 rtl/fifo_rd_stream.sv | 122 ++++++++++++
 tb/tb_fifo_rd_stream.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the FIFO read-side stream adapter.
//   DATASIZE    : width of FIFO read data and stream data
//   buf_state_t : occupancy state of the 2-entry skid buffer
//   occ_of()    : maps a buffer state to its entry count
package definitions;

  localparam int DATASIZE = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  function automatic logic [1:0] occ_of(input buf_state_t s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      ONE:     n = 2'd1;
      TWO:     n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream carrying FIFO words to a downstream consumer.
//   m_data  : stream beat data (DATASIZE bits)
//   m_valid : m_data holds a valid beat
//   m_ready : consumer accepts the beat; transfer on valid & ready
// Modports: master = producer (fifo_rd_stream), slave = consumer.
interface fifo_rd_stream_if;
  import definitions::*;

  logic [DATASIZE-1:0] m_data;
  logic                m_valid;
  logic                m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side adapter that pops an async FIFO into a valid/ready stream
// through a 2-entry buffer (head presented on the stream, tail as skid).
// Ports:
//   rclk, rrst_n : read clock, async-assert/sync-release active-low reset
//   rdata        : FIFO read data, valid while rempty is low
//   rempty       : FIFO empty flag
//   rinc         : FIFO pop request (combinational, independent of m_ready)
//   flush        : synchronous discard of buffered entries
//   m            : stream master (m_data, m_valid, m_ready)
//   occ          : buffered entry count 0..2
//   beat_cnt     : count of accepted stream transfers, wraps at 2^CNTW
module fifo_rd_stream
  import definitions::*;
#(
  parameter int CNTW = 16
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [DATASIZE-1:0] rdata,
  input  logic                rempty,
  output logic                rinc,
  input  logic                flush,
  fifo_rd_stream_if.master    m,
  output logic [1:0]          occ,
  output logic [CNTW-1:0]     beat_cnt
);

  buf_state_t          state_q, state_d;
  logic [DATASIZE-1:0] head_q, tail_q;
  logic                run_q;
  logic                valid_q;
  logic [1:0]          occ_q;
  logic [CNTW-1:0]     cnt_q;

  logic push, pop;
  logic ld_head, ld_tail, mv_tail;

  // Popping only while a slot is guaranteed free keeps rinc off the
  // m_ready path; TWO never pops, so a full buffer simply waits.
  assign rinc = run_q & ~rempty & ~flush & (state_q != TWO);
  assign push = rinc;
  assign pop  = valid_q & m.m_ready;

  always_comb begin
    state_d = state_q;
    ld_head = 1'b0;
    ld_tail = 1'b0;
    mv_tail = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            ld_head = 1'b1;
            state_d = ONE;
          end
        end
        ONE: begin
          if (push && !pop) begin
            ld_tail = 1'b1;
            state_d = TWO;
          end else if (pop && !push) begin
            state_d = EMPTY;
          end else if (push && pop) begin
            ld_head = 1'b1;
          end
        end
        TWO: begin
          if (pop) begin
            mv_tail = 1'b1;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Control state; valid/occ are registered copies of the next state so
  // every stream output comes straight from a flop.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      occ_q   <= 2'd0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d != EMPTY);
      occ_q   <= occ_of(state_d);
      run_q   <= 1'b1;
    end
  end

  // Buffer storage and transfer counter; a pop during flush still counts.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (ld_head) begin
        head_q <= rdata;
      end else if (mv_tail) begin
        head_q <= tail_q;
      end
      if (ld_tail) begin
        tail_q <= rdata;
      end
      if (pop) begin
        cnt_q <= cnt_q + CNTW'(1);
      end
    end
  end

  assign m.m_data  = head_q;
  assign m.m_valid = valid_q;
  assign occ       = occ_q;
  assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a behavioural FIFO feeds two DUTs
// (CNTW=16 and CNTW=4) with identical inputs; the narrow one exposes the
// beat counter wrap.
module tb_fifo_rd_stream;
  import definitions::*;

  logic rclk = 1'b0;
  logic rrst_n;
  logic flush;
  logic m_ready;

  logic [7:0]  mem [0:2047];
  logic [10:0] rd_ptr = 11'd0;
  logic [10:0] wr_ptr = 11'd0;
  logic [7:0]  rdata;
  logic        rempty;

  logic        rinc, rinc4;
  logic [1:0]  occ, occ4;
  logic [15:0] beat_cnt;
  logic [3:0]  beat_cnt4;

  int checks   = 0;
  int failures = 0;

  fifo_rd_stream_if s_if ();
  fifo_rd_stream_if s4_if ();
  assign s_if.m_ready  = m_ready;
  assign s4_if.m_ready = m_ready;

  fifo_rd_stream #(.CNTW(16)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty),
    .rinc(rinc), .flush(flush), .m(s_if), .occ(occ), .beat_cnt(beat_cnt)
  );

  fifo_rd_stream #(.CNTW(4)) dut4 (
    .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty),
    .rinc(rinc4), .flush(flush), .m(s4_if), .occ(occ4), .beat_cnt(beat_cnt4)
  );

  always #5 rclk = ~rclk;

  assign rempty = (rd_ptr == wr_ptr);
  assign rdata  = mem[rd_ptr];

  always @(posedge rclk) begin
    if (rinc && !rempty) rd_ptr <= rd_ptr + 11'd1;
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic put(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 11'd1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    bit started;
    bit wrap_done;
    logic [7:0] exp_d;

    rrst_n  = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b1;
    put(8'hA5);
    tick();
    tick();

    // reset values
    chk("rst_valid", {31'd0, s_if.m_valid}, 32'd0);
    chk("rst_data", {24'd0, s_if.m_data}, 32'd0);
    chk("rst_occ", {30'd0, occ}, 32'd0);
    chk("rst_cnt", {16'd0, beat_cnt}, 32'd0);
    chk("rst_rinc", {31'd0, rinc}, 32'd0);

    // first word after release
    rrst_n = 1'b1;
    settle();
    chk("c1_rinc", {31'd0, rinc}, 32'd0);
    tick();
    chk("c2_rinc", {31'd0, rinc}, 32'd1);
    tick();
    chk("c3_valid", {31'd0, s_if.m_valid}, 32'd1);
    chk("c3_data", {24'd0, s_if.m_data}, 32'hA5);
    chk("c3_occ", {30'd0, occ}, 32'd1);
    tick();
    chk("c4_cnt", {16'd0, beat_cnt}, 32'd1);
    chk("c4_valid", {31'd0, s_if.m_valid}, 32'd0);

    // backpressure
    m_ready = 1'b0;
    put(8'h01); put(8'h02); put(8'h03); put(8'h04);
    tick(); tick(); tick(); tick();
    chk("bp_occ", {30'd0, occ}, 32'd2);
    chk("bp_rinc", {31'd0, rinc}, 32'd0);
    chk("bp_data", {24'd0, s_if.m_data}, 32'h01);
    chk("bp_valid", {31'd0, s_if.m_valid}, 32'd1);
    chk("bp_pops", {21'd0, rd_ptr}, 32'd3);
    tick();
    chk("bp_hold", {24'd0, s_if.m_data}, 32'h01);
    m_ready = 1'b1;
    settle();
    chk("bp_b0", {24'd0, s_if.m_data}, 32'h01);
    tick();
    chk("bp_b1", {24'd0, s_if.m_data}, 32'h02);
    chk("bp_v1", {31'd0, s_if.m_valid}, 32'd1);
    tick();
    chk("bp_b2", {24'd0, s_if.m_data}, 32'h03);
    chk("bp_v2", {31'd0, s_if.m_valid}, 32'd1);
    tick();
    chk("bp_b3", {24'd0, s_if.m_data}, 32'h04);
    chk("bp_v3", {31'd0, s_if.m_valid}, 32'd1);
    tick();
    chk("bp_end_valid", {31'd0, s_if.m_valid}, 32'd0);
    chk("bp_end_cnt", {16'd0, beat_cnt}, 32'd5);

    // flush while holding two entries
    m_ready = 1'b0;
    put(8'h11); put(8'h22); put(8'h33);
    tick(); tick();
    chk("fl_pre_occ", {30'd0, occ}, 32'd2);
    m_ready = 1'b1;
    flush   = 1'b1;
    settle();
    chk("fl_rinc", {31'd0, rinc}, 32'd0);
    tick();
    chk("fl_occ", {30'd0, occ}, 32'd0);
    chk("fl_valid", {31'd0, s_if.m_valid}, 32'd0);
    chk("fl_cnt", {16'd0, beat_cnt}, 32'd6);
    flush   = 1'b0;
    m_ready = 1'b0;
    settle();
    chk("fl_resume_rinc", {31'd0, rinc}, 32'd1);
    tick();
    chk("fl_next_data", {24'd0, s_if.m_data}, 32'h33);
    chk("fl_next_occ", {30'd0, occ}, 32'd1);

    // asynchronous reset while holding two entries
    put(8'h44);
    tick();
    chk("ar_pre_occ", {30'd0, occ}, 32'd2);
    rrst_n = 1'b0;
    #2;
    chk("ar_valid", {31'd0, s_if.m_valid}, 32'd0);
    chk("ar_occ", {30'd0, occ}, 32'd0);
    chk("ar_cnt", {16'd0, beat_cnt}, 32'd0);
    chk("ar_rinc", {31'd0, rinc}, 32'd0);
    tick();
    tick();

    // streaming 1000 words
    m_ready = 1'b1;
    for (int i = 0; i < 1000; i++) put(8'((i * 7 + 3) & 255));
    rrst_n    = 1'b1;
    seen      = 0;
    started   = 1'b0;
    wrap_done = 1'b0;
    for (int c = 0; c < 1100 && seen < 1000; c++) begin
      if (seen == 17 && !wrap_done) begin
        chk("wrap_cnt4", {28'd0, beat_cnt4}, 32'd1);
        wrap_done = 1'b1;
      end
      if (started) chk("st_nogap", {31'd0, s_if.m_valid}, 32'd1);
      if (s_if.m_valid) begin
        exp_d = 8'((seen * 7 + 3) & 255);
        chk("st_data", {24'd0, s_if.m_data}, {24'd0, exp_d});
        seen++;
        started = 1'b1;
      end
      tick();
    end
    chk("st_seen", seen, 32'd1000);
    chk("st_cnt", {16'd0, beat_cnt}, 32'd1000);
    chk("st_cnt4", {28'd0, beat_cnt4}, 32'd8);
    chk("st_end_valid", {31'd0, s_if.m_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
